// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for elastic inter-stage pipeline registers.
package pipe_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // RV32 canonical NOP (addi x0,x0,0), used to build IF/ID bubbles.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake/payload bundle between a pipeline stage and its neighbours.
interface pipe_stage_if #(
  parameter int DATA_W = 192,
  parameter int CNT_W  = 16
);
  logic              IN_VALID;
  logic              IN_READY;
  logic [DATA_W-1:0] IN_DATA;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [DATA_W-1:0] OUT_DATA;
  logic              FLUSH;
  logic [1:0]        OCCUPANCY;
  logic [CNT_W-1:0]  STALL_CNT;
  logic              CNT_CLR;

  modport master (
    output IN_VALID, IN_DATA, OUT_READY, FLUSH, CNT_CLR,
    input  IN_READY, OUT_VALID, OUT_DATA, OCCUPANCY, STALL_CNT
  );

  modport slave (
    input  IN_VALID, IN_DATA, OUT_READY, FLUSH, CNT_CLR,
    output IN_READY, OUT_VALID, OUT_DATA, OCCUPANCY, STALL_CNT
  );
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             INC,
  input  logic             CLR,
  output logic [WIDTH-1:0] COUNT
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                              cnt_q <= '0;
    else if (CLR)                              cnt_q <= '0;
    else if (INC && (cnt_q != {WIDTH{1'b1}}))  cnt_q <= cnt_q + WIDTH'(1);
  end

  assign COUNT = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: valid/ready handshake, optional 2-entry skid,
// flush, bubble substitution and a stall counter.
module pipe_stage_reg
  import pipe_stage_pkg::*;
#(
  parameter int                 DATA_W       = 192,
  parameter logic [DATA_W-1:0]  BUBBLE_VALUE = '0,
  parameter int                 SKID         = 1,
  parameter int                 CNT_W        = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  pipe_stage_if.slave bus
);

  state_e            st_q;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              out_vld, in_rdy, accept, drain;

  assign out_vld = (st_q != ST_EMPTY);
  // With the skid entry, ready depends on state only, breaking OUT_READY->IN_READY.
  assign in_rdy  = (SKID != 0) ? (st_q != ST_FULL) : (!out_vld || bus.OUT_READY);
  assign accept  = bus.IN_VALID && in_rdy;
  assign drain   = out_vld && bus.OUT_READY;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)       st_q <= ST_EMPTY;
    else if (bus.FLUSH) st_q <= ST_EMPTY;
    else begin
      case (st_q)
        ST_EMPTY: if (accept) st_q <= ST_ONE;
        ST_ONE: begin
          if (accept && !drain)      st_q <= (SKID != 0) ? ST_FULL : ST_ONE;
          else if (drain && !accept) st_q <= ST_EMPTY;
        end
        ST_FULL:  if (drain) st_q <= ST_ONE;
        default:  st_q <= ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    case (st_q)
      ST_EMPTY: if (accept) main_d = bus.IN_DATA;
      ST_ONE: begin
        if (accept && drain) main_d = bus.IN_DATA;
        else if (accept)     skid_d = bus.IN_DATA;
      end
      ST_FULL:  if (drain) main_d = skid_q;
      default: ;
    endcase
  end

  // Payload registers carry no reset; validity lives entirely in st_q.
  always_ff @(posedge CLK) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

  assign bus.IN_READY  = in_rdy;
  assign bus.OUT_VALID = out_vld;
  assign bus.OUT_DATA  = out_vld ? main_q : BUBBLE_VALUE;
  assign bus.OCCUPANCY = st_q;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .INC     (out_vld && !bus.OUT_READY),
    .CLR     (bus.CNT_CLR),
    .COUNT   (bus.STALL_CNT)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Two instances (skid IF/ID-style and skidless) checked against a FIFO model.
module tb_pipe_stage_reg;
  import pipe_stage_pkg::*;

  logic CLK;
  logic RESET_N;

  pipe_stage_if #(.DATA_W(32), .CNT_W(4))  a_if ();
  pipe_stage_if #(.DATA_W(32), .CNT_W(16)) b_if ();

  pipe_stage_reg #(.DATA_W(32), .BUBBLE_VALUE(NOP_INSTR), .SKID(1), .CNT_W(4)) u_a (
    .CLK(CLK), .RESET_N(RESET_N), .bus(a_if.slave));
  pipe_stage_reg #(.DATA_W(32), .BUBBLE_VALUE(32'h0), .SKID(0), .CNT_W(16)) u_b (
    .CLK(CLK), .RESET_N(RESET_N), .bus(b_if.slave));

  logic        iv [2];
  logic [31:0] id [2];
  logic        ordy [2];
  logic        fl [2];
  logic        clr [2];
  logic        ov [2];
  logic [31:0] od [2];
  logic        ir [2];
  logic [1:0]  occ [2];
  logic [31:0] sc [2];

  assign a_if.IN_VALID = iv[0];   assign b_if.IN_VALID = iv[1];
  assign a_if.IN_DATA  = id[0];   assign b_if.IN_DATA  = id[1];
  assign a_if.OUT_READY = ordy[0]; assign b_if.OUT_READY = ordy[1];
  assign a_if.FLUSH    = fl[0];   assign b_if.FLUSH    = fl[1];
  assign a_if.CNT_CLR  = clr[0];  assign b_if.CNT_CLR  = clr[1];
  assign ov[0]  = a_if.OUT_VALID; assign ov[1]  = b_if.OUT_VALID;
  assign od[0]  = a_if.OUT_DATA;  assign od[1]  = b_if.OUT_DATA;
  assign ir[0]  = a_if.IN_READY;  assign ir[1]  = b_if.IN_READY;
  assign occ[0] = a_if.OCCUPANCY; assign occ[1] = b_if.OCCUPANCY;
  assign sc[0]  = {28'd0, a_if.STALL_CNT};
  assign sc[1]  = {16'd0, b_if.STALL_CNT};

  // Reference: an ordered list of held payloads plus a stall tally.
  logic [31:0] mdat [2][2];
  int          mcnt [2];
  int          mstall [2];
  logic [31:0] bub [2];
  int          smax [2];

  int total = 0;
  int bad   = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_rdy(input int k);
    if (k == 0) return mcnt[k] < 2;
    return (mcnt[k] == 0) || ordy[k];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k]   = 0;
      mstall[k] = 0;
    end
  endtask

  // Check current outputs, then advance the model across the coming edge.
  task automatic tick();
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      logic acc, drn;
      chk(k == 0 ? "a_ovld" : "b_ovld", {31'd0, ov[k]}, {31'd0, mcnt[k] != 0});
      chk(k == 0 ? "a_odat" : "b_odat", od[k], (mcnt[k] != 0) ? mdat[k][0] : bub[k]);
      chk(k == 0 ? "a_occ"  : "b_occ",  {30'd0, occ[k]}, mcnt[k]);
      chk(k == 0 ? "a_irdy" : "b_irdy", {31'd0, ir[k]}, {31'd0, exp_rdy(k)});
      chk(k == 0 ? "a_scnt" : "b_scnt", sc[k], mstall[k]);
      acc = iv[k] && exp_rdy(k);
      drn = (mcnt[k] != 0) && ordy[k];
      if (clr[k]) mstall[k] = 0;
      else if ((mcnt[k] != 0) && !ordy[k] && mstall[k] < smax[k]) mstall[k]++;
      if (fl[k]) mcnt[k] = 0;
      else begin
        if (drn) begin
          mdat[k][0] = mdat[k][1];
          mcnt[k]--;
        end
        if (acc) begin
          mdat[k][mcnt[k]] = id[k];
          mcnt[k]++;
        end
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int k);
    iv[k] = 1'b0; ordy[k] = 1'b1; fl[k] = 1'b0; clr[k] = 1'b0; id[k] = 32'hDEAD_0000;
  endtask

  initial begin
    bub[0] = NOP_INSTR; bub[1] = 32'h0;
    smax[0] = 15;       smax[1] = 65535;
    model_reset();
    idle(0); idle(1);
    RESET_N = 1'b0;
    #3;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ovld", {31'd0, ov[k]}, 32'd0);
      chk("rst_odat", od[k], bub[k]);
      chk("rst_irdy", {31'd0, ir[k]}, 32'd1);
      chk("rst_occ",  {30'd0, occ[k]}, 32'd0);
      chk("rst_scnt", sc[k], 32'd0);
    end
    #9 RESET_N = 1'b1;
    @(posedge CLK); #1;

    // Back-to-back stream through the skid instance.
    for (int i = 1; i <= 4; i++) begin
      iv[0] = 1'b1; id[0] = i;
      tick();
    end
    idle(0);
    for (int i = 0; i < 3; i++) tick();

    // Backpressure: 5 in main, 6 into skid, 7 held upstream.
    iv[0] = 1'b1; id[0] = 32'd5; ordy[0] = 1'b0; tick();
    id[0] = 32'd6; tick();
    chk("bp_occ", {30'd0, occ[0]}, 32'd2);
    chk("bp_irdy", {31'd0, ir[0]}, 32'd0);
    id[0] = 32'd7; tick();
    ordy[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) iv[0] = 1'b0;
    end
    chk("bp_stall", sc[0], 32'd2);
    idle(0); tick();

    // Flush together with an accept: neither 8 nor 9 may surface.
    iv[0] = 1'b1; id[0] = 32'd8; ordy[0] = 1'b0; tick();
    fl[0] = 1'b1; id[0] = 32'd9; tick();
    chk("fl_ovld", {31'd0, ov[0]}, 32'd0);
    chk("fl_odat", od[0], 32'h0000_0013);
    chk("fl_occ",  {30'd0, occ[0]}, 32'd0);
    idle(0); tick(); tick();

    // Skidless: ready follows OUT_READY combinationally.
    iv[1] = 1'b1; id[1] = 32'hB0; tick();
    iv[1] = 1'b0; ordy[1] = 1'b0; #1;
    chk("b_comb_lo", {31'd0, ir[1]}, 32'd0);
    ordy[1] = 1'b1; #1;
    chk("b_comb_hi", {31'd0, ir[1]}, 32'd1);
    iv[1] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      id[1] = 32'hB0 + i;
      tick();
    end
    idle(1); tick();

    // Saturation on the 4-bit counter, then clear during a stall.
    clr[0] = 1'b1; tick(); clr[0] = 1'b0;
    iv[0] = 1'b1; id[0] = 32'hC0; ordy[0] = 1'b0; tick();
    iv[0] = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_hold", sc[0], 32'd15);
    clr[0] = 1'b1; tick();
    chk("sat_clr", sc[0], 32'd0);
    clr[0] = 1'b0; tick();
    idle(0); tick();

    // Asynchronous reset while full.
    iv[0] = 1'b1; ordy[0] = 1'b0; id[0] = 32'hD1; tick();
    id[0] = 32'hD2; tick();
    iv[0] = 1'b0; tick();
    chk("pre_rst_occ", {30'd0, occ[0]}, 32'd2);
    #1 RESET_N = 1'b0;
    #1;
    chk("arst_ovld", {31'd0, ov[0]}, 32'd0);
    chk("arst_occ",  {30'd0, occ[0]}, 32'd0);
    chk("arst_scnt", sc[0], 32'd0);
    chk("arst_odat", od[0], NOP_INSTR);
    model_reset();
    #1 RESET_N = 1'b1;
    idle(0);
    iv[0] = 1'b1; id[0] = 32'hAB; tick();
    chk("post_rst", od[0], 32'hAB);
    idle(0); tick();

    // Randomized traffic on both instances.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        iv[k]   = ($urandom_range(9, 0) < 7);
        id[k]   = $urandom;
        ordy[k] = ($urandom_range(9, 0) < 6);
        fl[k]   = ($urandom_range(15, 0) == 0);
        clr[k]  = ($urandom_range(31, 0) == 0);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register for the RV32IM five-stage pipeline, replacing the fixed-width, always-enabled inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque payload with a valid/ready handshake and an optional 2-entry skid buffer, so no combinational path runs from OUT_READY to IN_READY. It also provides synchronous flush for branch/jump squashing, bubble injection with a configurable NOP payload, and a saturating stall counter for performance analysis.

## Interface
- DATA_W, 192, payload width in bits (ID/EX bundle: PC, PC+4, IMM, DATA1, DATA2, FUNC3, RD, control)
- BUBBLE_VALUE, {DATA_W{1'b0}}, OUT_DATA value whenever OUT_VALID=0
- SKID, 1, 1 = 2-entry skid buffer with registered IN_READY; 0 = single entry with combinational IN_READY
- CNT_W, 16, stall counter width
- CLK  in  1  single clock; all state updates on the rising edge
- RESET_N  in  1  asynchronous, active-low reset
- IN_VALID  in  1  upstream payload valid
- IN_READY  out  1  stage can accept a payload this cycle
- IN_DATA  in  DATA_W  upstream payload
- OUT_VALID  out  1  payload present at the head
- OUT_READY  in  1  downstream accepts the head this cycle
- OUT_DATA  out  DATA_W  head payload, or BUBBLE_VALUE when empty
- FLUSH  in  1  squash all held entries and any payload offered this cycle
- OCCUPANCY  out  2  entries held (0..2; never exceeds 1 when SKID=0)
- STALL_CNT  out  CNT_W  saturating count of cycles with OUT_VALID=1 and OUT_READY=0
- CNT_CLR  in  1  synchronous clear of STALL_CNT

## Operation
- States: EMPTY (occupancy 0), ONE (main register valid), FULL (main and skid valid; SKID=1 only).
- Accept = IN_VALID & IN_READY. Drain = OUT_VALID & OUT_READY.
- EMPTY: on accept, go to ONE and load main.
- ONE: on accept without drain, go to FULL (load skid). On drain without accept, go to EMPTY. On accept and drain, stay in ONE (load main).
- FULL: on drain, go to ONE and move skid to main. No accept is possible in FULL.
- IN_READY:
  - SKID=1: IN_READY = (state != FULL). It is a function of state only.
  - SKID=0: IN_READY = !OUT_VALID | OUT_READY.
- FIFO ordering is strict. A payload is never duplicated or dropped except by FLUSH.
- OUT_DATA = main when OUT_VALID is high, otherwise BUBBLE_VALUE. When empty, the downstream stage therefore sees a NOP bundle.
- FLUSH has the highest priority:
  - The next state is EMPTY.
  - A payload accepted in the same cycle is discarded.
  - A drain in the same cycle still counts as consumed downstream.
- STALL_CNT:
  - Increments by 1 per stall cycle and saturates at all-ones.
  - CNT_CLR has priority over increment.
  - FLUSH does not clear it.
- Asynchronous reset:
  - State goes to EMPTY; OUT_VALID=0, OUT_DATA=BUBBLE_VALUE, OCCUPANCY=0, STALL_CNT=0.
  - IN_READY=1 for SKID=1. For SKID=0, IN_READY=1 by its equation.
  - Reset asserted mid-transfer loses held entries without any handshake.

## Timing
- Latency: 1 cycle from accept to OUT_VALID (EMPTY to ONE).
- Throughput: 1 payload/cycle sustained while OUT_READY=1, for both SKID settings.
- SKID=1: IN_READY updates one edge after OUT_READY changes. The skid entry absorbs the single in-flight payload.
- SKID=0: IN_READY follows OUT_READY combinationally within the same cycle.
- FLUSH takes effect at the next edge: OUT_VALID=0 and OUT_DATA=BUBBLE_VALUE in the following cycle.
- OCCUPANCY and STALL_CNT are registered and reflect the state after the last edge.

## Structure
- Shared package pipe_stage_pkg holds:
  - state encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2;
  - RV32 bubble constant NOP_INSTR=32'h00000013, used by IF/ID instances to build BUBBLE_VALUE.
- Sub-module sat_counter (params WIDTH; ports CLK, RESET_N, INC, CLR, COUNT) implements STALL_CNT and is reused by other stages' performance counters.
- Datapath: main and skid registers of DATA_W bits, no reset on data (only valid/state bits are reset), plus an output mux to BUBBLE_VALUE.

## Test plan
- Reset then stream, SKID=1, DATA_W=32, OUT_READY=1: IN_DATA=1,2,3,4 on consecutive cycles -> OUT_DATA 1,2,3,4 one cycle later, back-to-back; IN_READY stays 1; STALL_CNT=0.
- Backpressure: after loading 5, hold OUT_READY=0 while offering 6 and 7 -> 6 is accepted into skid, OCCUPANCY=2, IN_READY=0 next cycle, 7 is held upstream. Release OUT_READY -> output order 5,6,7. STALL_CNT equals the number of stalled cycles.
- Flush with simultaneous accept: in state ONE holding 8, assert FLUSH together with IN_VALID (data 9) -> next cycle OUT_VALID=0, OUT_DATA=BUBBLE_VALUE (32'h00000013 on an IF/ID instance), OCCUPANCY=0; neither 8 nor 9 ever appears.
- SKID=0: with OUT_VALID=1, drop OUT_READY -> IN_READY falls in the same cycle. Raise OUT_READY with IN_VALID=1 -> one-for-one replacement and OCCUPANCY never exceeds 1.
- Counter saturation: CNT_W=4, stall for 20 cycles -> STALL_CNT=15 and holds. CNT_CLR together with a stall cycle -> 0.
- Asynchronous reset mid-operation: in FULL, drive RESET_N low off-edge -> OUT_VALID=0, OCCUPANCY=0, STALL_CNT=0 immediately without a clock edge. After release, the first accept appears one cycle later.
